sccb_reg_access: RTL and testbench
==================================

Name: sccb_reg_access

Overview:
- Sits between the OV7670 camera driver (HCI front end) and the AXI-stream i2c master.
- Converts one register request (write, or read of one OV7670 register) into the SCCB-legal command/data sequence:
  - write: one 3-phase write;
  - read: a 2-phase write, a stop, then a 2-phase read (no repeated start).
- Returns a single-cycle response carrying the read data or a timeout flag.
- Enforces bus-free gaps between SCCB transactions.

Parameters:
- DEV_ADDR, 7'h21: 7-bit SCCB device ID of the OV7670.
- GAP_CYCLES, 500: idle clk cycles after every stop (minimum 1).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles spent waiting in any single handshake state.

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  8  OV7670 register address
- req_wdata  in  8  write value (ignored for reads)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read value (0 for writes and timeouts)
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted
- busy  out  1  high whenever the state is not IDLE
- s_axis_cmd_address  out  7  i2c master command: device address
- s_axis_cmd_start, s_axis_cmd_read, s_axis_cmd_write, s_axis_cmd_write_multiple, s_axis_cmd_stop  out  1 each  i2c master command flags
- s_axis_cmd_valid  out  1 / s_axis_cmd_ready  in  1  i2c master command handshake
- s_axis_data_tdata  out  8 / s_axis_data_tvalid  out  1 / s_axis_data_tready  in  1 / s_axis_data_tlast  out  1  write data stream to i2c master
- m_axis_data_tdata  in  8 / m_axis_data_tvalid  in  1 / m_axis_data_tready  out  1 / m_axis_data_tlast  in  1  read data stream from i2c master

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Asynchronous active-low reset forces state IDLE and all outputs 0, including req_ready.
  - The first cycle after reset release shows req_ready=1.
  - Reset mid-transaction abandons the transaction immediately; no rsp_valid is issued.
- Request acceptance:
  - req_ready = (state==IDLE).
  - Accept on req_valid&&req_ready; latch req_write, req_addr, req_wdata.
  - The next state is entered on the following cycle.
- Command outputs:
  - s_axis_cmd_address is always DEV_ADDR.
  - Command flags are registered and are 0 outside CMD states.
  - Every valid holds stable until its ready; no data change while valid&&!ready.
- Write path:
  - W_CMD: cmd start=1, write_multiple=1, stop=1, valid=1 until cmd_ready.
  - W_ADDR: tdata=req_addr, tlast=0, tvalid until tready.
  - W_VAL: tdata=req_wdata, tlast=1 until tready.
  - Then GAP, then RESP.
- Read path:
  - R_CMD0: start=1, write=1, stop=1.
  - R_ADDR: tdata=req_addr, tlast=1.
  - R_GAP: wait GAP_CYCLES.
  - R_CMD1: start=1, read=1, stop=1.
  - R_WAIT: wait for m_axis_data_tvalid; capture tdata into rsp_rdata on that cycle.
  - Then GAP, then RESP.
- Read stream ready:
  - m_axis_data_tready=1 in every non-reset state so stray bytes never stall the master.
  - Data is captured only in R_WAIT.
- GAP: counts GAP_CYCLES cycles, then moves to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata and rsp_timeout hold their values until the next acceptance.
- Timeout:
  - One 20-bit down-counter (sized to clog2(max(GAP,TIMEOUT)+1)).
  - Loaded on entry to every handshake-wait state (W_CMD, W_ADDR, W_VAL, R_CMD0, R_ADDR, R_CMD1, R_WAIT).
  - Reaching 0 before the handshake completes: deassert all valids, set the timeout flag, go to GAP, then RESP with rsp_timeout=1 and rsp_rdata=0.
  - The abort is intentional and accepted: the master is considered hung.
- Same counter is reused for GAP/R_GAP.
- A handshake completing on the same cycle the counter hits 0 counts as success.
- Latency: write with always-ready master = 1 accept + 3 handshake cycles + GAP_CYCLES + 1 RESP.

Decomposition:
- sccb_pkg:
  - state enum (IDLE, W_CMD, W_ADDR, W_VAL, R_CMD0, R_ADDR, R_GAP, R_CMD1, R_WAIT, GAP, RESP);
  - OV7670_DEV_ADDR constant;
  - packed cmd_flags_t struct {start, read, write, write_multiple, stop}.
- No sub-module: one FSM plus one shared down-counter.

Test Plan:
- Write: reset, then req write addr=8'h12 data=8'h80 with master always ready -> one command (start,write_multiple,stop, address 7'h21), bytes 12 (tlast=0), 80 (tlast=1), rsp_valid after GAP_CYCLES+1, rsp_timeout=0.
- Read: read addr=8'h0A, master returns 8'h76 -> cmd(write,stop), byte 0A tlast=1, ≥GAP_CYCLES idle, cmd(read,stop), rsp_rdata=8'h76.
- Backpressure: randomly stall cmd_ready/tready for 0-20 cycles -> valid/data stable while stalled, same byte sequence as unstalled run.
- Timeout: TIMEOUT_CYCLES=100, cmd_ready stuck 0 -> cmd_valid drops after 100 cycles, rsp_valid with rsp_timeout=1, rsp_rdata=0; next request accepted normally.
- Reset mid-transaction: assert reset_ during W_ADDR -> all outputs 0 asynchronously, no rsp_valid; a following write completes correctly.
- Acceptance rule: req_valid held high across two requests -> second request accepted only after RESP; req_ready low while busy=1.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types for the OV7670 SCCB register-access block: FSM states,
// i2c master command flag bundle and the camera's default device ID.
package sccb_pkg;

    localparam logic [6:0] OV7670_DEV_ADDR = 7'h21;

    typedef enum logic [3:0] {
        IDLE,
        W_CMD,
        W_ADDR,
        W_VAL,
        R_CMD0,
        R_ADDR,
        R_GAP,
        R_CMD1,
        R_WAIT,
        GAP,
        RESP
    } state_t;

    typedef struct packed {
        logic start;
        logic read;
        logic write;
        logic write_multiple;
        logic stop;
    } cmd_flags_t;

    // Command flags presented while the FSM sits in a command state.
    function automatic cmd_flags_t cmd_flags_for(input state_t s);
        cmd_flags_t f;
        f = '0;
        case (s)
            W_CMD: begin
                f.start          = 1'b1;
                f.write_multiple = 1'b1;
                f.stop           = 1'b1;
            end
            R_CMD0: begin
                f.start = 1'b1;
                f.write = 1'b1;
                f.stop  = 1'b1;
            end
            R_CMD1: begin
                f.start = 1'b1;
                f.read  = 1'b1;
                f.stop  = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sccb_reg_access.sv
// OV7670 register access over SCCB: turns one register request into the
// command/data sequence for an AXI-stream i2c master, with gaps and timeouts.
module sccb_reg_access
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = OV7670_DEV_ADDR,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_,

    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,

    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       busy,

    output logic [6:0] s_axis_cmd_address,
    output logic       s_axis_cmd_start,
    output logic       s_axis_cmd_read,
    output logic       s_axis_cmd_write,
    output logic       s_axis_cmd_write_multiple,
    output logic       s_axis_cmd_stop,
    output logic       s_axis_cmd_valid,
    input  logic       s_axis_cmd_ready,

    output logic [7:0] s_axis_data_tdata,
    output logic       s_axis_data_tvalid,
    input  logic       s_axis_data_tready,
    output logic       s_axis_data_tlast,

    input  logic [7:0] m_axis_data_tdata,
    input  logic       m_axis_data_tvalid,
    output logic       m_axis_data_tready,
    input  logic       m_axis_data_tlast
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       addr_q, wdata_q;

    logic             accept, capture, abort;
    cmd_flags_t       flags_q, flags_next;
    logic             cmd_valid_next, tvalid_next, tlast_next;
    logic [7:0]       tdata_next;

    logic             unused;
    assign unused = m_axis_data_tlast;

    always_comb begin
        state_next = state;
        cnt_next   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = req_write ? W_CMD : R_CMD0;
                end
            end
            W_CMD:  if (s_axis_cmd_ready)        state_next = W_ADDR; else if (cnt == '0) abort = 1'b1;
            W_ADDR: if (s_axis_data_tready)      state_next = W_VAL;  else if (cnt == '0) abort = 1'b1;
            W_VAL:  if (s_axis_data_tready)      state_next = GAP;    else if (cnt == '0) abort = 1'b1;
            R_CMD0: if (s_axis_cmd_ready)        state_next = R_ADDR; else if (cnt == '0) abort = 1'b1;
            R_ADDR: if (s_axis_data_tready)      state_next = R_GAP;  else if (cnt == '0) abort = 1'b1;
            R_GAP:  if (cnt == '0)               state_next = R_CMD1;
            R_CMD1: if (s_axis_cmd_ready)        state_next = R_WAIT; else if (cnt == '0) abort = 1'b1;
            R_WAIT: begin
                if (m_axis_data_tvalid) begin
                    capture    = 1'b1;
                    state_next = GAP;
                end else if (cnt == '0) begin
                    abort = 1'b1;
                end
            end
            GAP:     if (cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (abort) state_next = GAP;

        // One counter serves both gap timing and handshake timeouts; reload on every state change.
        if (state_next != state) begin
            case (state_next)
                GAP, R_GAP: cnt_next = GAP_LOAD;
                IDLE, RESP: cnt_next = '0;
                default:    cnt_next = TO_LOAD;
            endcase
        end

        // Interface outputs are decoded from the next state so they register alongside it.
        flags_next     = cmd_flags_for(state_next);
        cmd_valid_next = (state_next == W_CMD) || (state_next == R_CMD0) || (state_next == R_CMD1);
        tvalid_next    = (state_next == W_ADDR) || (state_next == W_VAL) || (state_next == R_ADDR);
        tlast_next     = (state_next == W_VAL) || (state_next == R_ADDR);
        case (state_next)
            W_ADDR, R_ADDR: tdata_next = addr_q;
            W_VAL:          tdata_next = wdata_q;
            default:        tdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state              <= IDLE;
            cnt                <= '0;
            addr_q             <= '0;
            wdata_q            <= '0;
            flags_q            <= '0;
            s_axis_cmd_valid   <= 1'b0;
            s_axis_cmd_address <= '0;
            s_axis_data_tdata  <= '0;
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tlast  <= 1'b0;
            m_axis_data_tready <= 1'b0;
            req_ready          <= 1'b0;
            busy               <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_timeout        <= 1'b0;
        end else begin
            state              <= state_next;
            cnt                <= cnt_next;
            flags_q            <= flags_next;
            s_axis_cmd_valid   <= cmd_valid_next;
            s_axis_cmd_address <= DEV_ADDR;
            s_axis_data_tdata  <= tdata_next;
            s_axis_data_tvalid <= tvalid_next;
            s_axis_data_tlast  <= tlast_next;
            m_axis_data_tready <= 1'b1;
            req_ready          <= (state_next == IDLE);
            busy               <= (state_next != IDLE);
            rsp_valid          <= (state_next == RESP);
            if (accept) begin
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                rsp_rdata   <= '0;
                rsp_timeout <= 1'b0;
            end
            if (capture) rsp_rdata   <= m_axis_data_tdata;
            if (abort)   rsp_timeout <= 1'b1;
        end
    end

    assign s_axis_cmd_start          = flags_q.start;
    assign s_axis_cmd_read           = flags_q.read;
    assign s_axis_cmd_write          = flags_q.write;
    assign s_axis_cmd_write_multiple = flags_q.write_multiple;
    assign s_axis_cmd_stop           = flags_q.stop;

endmodule

// File: tb/tb_sccb_reg_access.sv
// Directed bench for sccb_reg_access: an i2c-master model logs every handshake,
// and a vector table plus hand-written sequences check responses and byte order.
module tb_sccb_reg_access;

    localparam int unsigned G  = 8;
    localparam int unsigned TO = 100;

    logic       clk, reset_;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_timeout, busy;
    logic [7:0] rsp_rdata;
    logic [6:0] cmd_address;
    logic       cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop, cmd_valid, cmd_ready;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tready, s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tready, m_tlast;

    sccb_reg_access #(
        .DEV_ADDR      (7'h21),
        .GAP_CYCLES    (G),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                      (clk),
        .reset_                   (reset_),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_write                (req_write),
        .req_addr                 (req_addr),
        .req_wdata                (req_wdata),
        .rsp_valid                (rsp_valid),
        .rsp_rdata                (rsp_rdata),
        .rsp_timeout              (rsp_timeout),
        .busy                     (busy),
        .s_axis_cmd_address       (cmd_address),
        .s_axis_cmd_start         (cmd_start),
        .s_axis_cmd_read          (cmd_read),
        .s_axis_cmd_write         (cmd_write),
        .s_axis_cmd_write_multiple(cmd_wm),
        .s_axis_cmd_stop          (cmd_stop),
        .s_axis_cmd_valid         (cmd_valid),
        .s_axis_cmd_ready         (cmd_ready),
        .s_axis_data_tdata        (s_tdata),
        .s_axis_data_tvalid       (s_tvalid),
        .s_axis_data_tready       (s_tready),
        .s_axis_data_tlast        (s_tlast),
        .m_axis_data_tdata        (m_tdata),
        .m_axis_data_tvalid       (m_tvalid),
        .m_axis_data_tready       (m_tready),
        .m_axis_data_tlast        (m_tlast)
    );

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rbyte;
        bit         stall;
        bit         hang;
        logic [7:0] exp_rdata;
        bit         exp_to;
    } vec_t;

    int n_vec = 0;
    int n_fail = 0;

    // master-model state and observations
    bit          stall = 0, hang = 0, block_data = 0;
    logic [7:0]  rd_byte = '0;
    int          cyc = 0, rd_delay = 0;
    int          stab_err = 0, addr_err = 0, mtr_err = 0, cv_cnt = 0;
    int          last_tlast_cyc = 0, gap_meas = 0;
    logic [15:0] log_q[$];
    logic [15:0] exp_q[$];
    bit          cmd_pend = 0, dat_pend = 0;
    logic [4:0]  cmd_prev;
    logic [8:0]  dat_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // i2c master model: drives readies at negedge, samples handshakes 4ns later
    initial begin
        cmd_ready = 1'b0;
        s_tready  = 1'b0;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            cmd_ready = hang ? 1'b0 : (stall ? ($urandom_range(0, 2) == 0) : 1'b1);
            s_tready  = block_data ? 1'b0 : (stall ? ($urandom_range(0, 2) == 0) : 1'b1);
            if (rd_delay == 1) begin
                m_tvalid = 1'b1; m_tdata = rd_byte; m_tlast = 1'b1;
            end else begin
                m_tvalid = 1'b0; m_tdata = '0; m_tlast = 1'b0;
            end
            if (rd_delay != 0) rd_delay--;
            #4;
            if (!reset_) begin
                cmd_pend = 0;
                dat_pend = 0;
            end else begin
                if (cmd_pend && !(cmd_valid && {cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop} == cmd_prev))
                    stab_err++;
                if (dat_pend && !(s_tvalid && {s_tlast, s_tdata} == dat_prev))
                    stab_err++;
                cmd_pend = cmd_valid && !cmd_ready;
                cmd_prev = {cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop};
                dat_pend = s_tvalid && !s_tready;
                dat_prev = {s_tlast, s_tdata};
                if (cmd_valid) cv_cnt++;
                if (cmd_valid && cmd_ready) begin
                    log_q.push_back({3'b001, 8'h00, cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop});
                    if (cmd_address != 7'h21) addr_err++;
                    if (cmd_read) begin
                        rd_delay = 4;
                        gap_meas = cyc - last_tlast_cyc;
                    end
                end
                if (s_tvalid && s_tready) begin
                    log_q.push_back({3'b010, 4'h0, s_tlast, s_tdata});
                    if (s_tlast) last_tlast_cyc = cyc;
                end
                if (m_tvalid && !m_tready) mtr_err++;
            end
        end
    end

    task automatic build_exp(input vec_t v);
        exp_q.delete();
        if (v.hang) return;
        if (v.wr) begin
            exp_q.push_back({3'b001, 8'h00, 5'b10011});
            exp_q.push_back({3'b010, 4'h0, 1'b0, v.addr});
            exp_q.push_back({3'b010, 4'h0, 1'b1, v.wdata});
        end else begin
            exp_q.push_back({3'b001, 8'h00, 5'b10101});
            exp_q.push_back({3'b010, 4'h0, 1'b1, v.addr});
            exp_q.push_back({3'b001, 8'h00, 5'b11001});
        end
    endtask

    function automatic bit seq_matches();
        if (log_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output int acc_cyc, output bit ok);
        ok = 0;
        acc_cyc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        for (int k = 0; k < 3000; k++) begin
            #3;
            if (req_ready) begin
                ok = 1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output int rsp_cyc);
        got = 0;
        rsp_cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #3;
            if (rsp_valid) begin
                got = 1;
                rsp_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int acc_c, rsp_c;
        bit ok, got;
        logic [7:0] rd_hold;
        stall = v.stall; hang = v.hang; rd_byte = v.rbyte;
        log_q.delete();
        stab_err = 0; addr_err = 0; mtr_err = 0; cv_cnt = 0; gap_meas = 0;
        build_exp(v);
        do_req(v.wr, v.addr, v.wdata, acc_c, ok);
        check({tag, ".accept"}, ok, 1);
        wait_rsp(got, rsp_c);
        check({tag, ".rsp_seen"}, got, 1);
        check({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, ".rsp_timeout"}, rsp_timeout, v.exp_to);
        rd_hold = rsp_rdata;
        check({tag, ".sequence"}, seq_matches(), 1);
        check({tag, ".cmd_address"}, addr_err, 0);
        check({tag, ".m_tready"}, mtr_err, 0);
        if (!v.hang) check({tag, ".stable"}, stab_err, 0);
        if (!v.wr && !v.hang) check({tag, ".gap_ge"}, (gap_meas - 1) >= G, 1);
        if (v.wr && !v.stall && !v.hang) check({tag, ".latency"}, rsp_c - acc_c, G + 4);
        if (v.hang) check({tag, ".cmd_valid_cycles"}, cv_cnt, TO);
        @(negedge clk);
        #3;
        check({tag, ".rsp_one_cycle"}, {rsp_valid, req_ready}, 2'b01);
        check({tag, ".rdata_hold"}, rsp_rdata, rd_hold);
        stall = 0; hang = 0;
    endtask

    function automatic logic [31:0] all_outputs();
        return {req_ready, rsp_valid, rsp_rdata, rsp_timeout, busy, cmd_address,
                cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop, cmd_valid,
                s_tvalid, s_tlast, m_tready} | {24'h0, s_tdata};
    endfunction

    vec_t vecs[7];

    initial begin
        int acc_c, rsp_c, rsp_seen, viol, rsp_cnt, rsp_at, acc_b;
        bit ok, got;
        vec_t v;

        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_c, rsp_c, rsp_seen, viol, rsp_cnt, rsp_at, acc_b;
        bit ok, got;
        vec_t v;

        //           wr    addr   wdata  rbyte  stall hang exp_rd exp_to
        vecs[0] = '{1'b1, 8'h12, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h0A, 8'h00, 8'h76, 1'b0, 1'b0, 8'h76, 1'b0};
        vecs[2] = '{1'b1, 8'h3A, 8'h04, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h1C, 8'h00, 8'h7F, 1'b1, 1'b0, 8'h7F, 1'b0};
        vecs[4] = '{1'b1, 8'h40, 8'hD0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 8'h0B, 8'h00, 8'h73, 1'b0, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h6B, 8'h00, 8'h0A, 1'b0, 1'b0, 8'h0A, 1'b0};

        reset_ = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        #3;
        check("reset.outputs_zero", all_outputs(), 0);
        #1 reset_ = 1'b1;
        @(negedge clk);
        #3;
        check("reset.req_ready_after", {req_ready, busy, m_tready}, 3'b101);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // reset while a write is stalled in its register-address byte
        block_data = 1;
        do_req(1'b1, 8'h55, 8'hAA, acc_c, ok);
        check("midreset.accept", ok, 1);
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (s_tvalid) begin
                got = 1;
                break;
            end
        end
        check("midreset.in_w_addr", {got, s_tdata, s_tlast}, {1'b1, 8'h55, 1'b0});
        @(negedge clk);
        #1 reset_ = 1'b0;
        #1 check("midreset.outputs_zero", all_outputs(), 0);
        rsp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            #3;
            if (rsp_valid) rsp_seen++;
        end
        @(negedge clk);
        #1 reset_ = 1'b1;
        block_data = 0;
        for (int k = 0; k < 2 * int'(G) + 10; k++) begin
            @(negedge clk);
            #3;
            if (rsp_valid) rsp_seen++;
        end
        check("midreset.no_rsp", rsp_seen, 0);
        check("midreset.idle", {req_ready, busy}, 2'b10);
        v = '{1'b1, 8'h11, 8'h2C, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        run_vec("after_reset", v);

        // req_valid held across two back-to-back requests
        rd_byte = 8'h5C;
        log_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'h31;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            #3;
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("hold.accept_a", ok, 1);
        @(negedge clk);
        req_write = 1'b0; req_addr = 8'h0A; req_wdata = 8'h00;
        viol = 0; rsp_cnt = 0; rsp_at = 0; acc_b = 0;
        for (int k = 0; k < 3000; k++) begin
            #3;
            if (busy && req_ready) viol++;
            if (!busy && !req_ready) viol++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_at = cyc;
            end
            if (req_ready) begin
                acc_b = cyc;
                break;
            end
            @(negedge clk);
        end
        check("hold.ready_vs_busy", viol, 0);
        check("hold.rsp_before_b", rsp_cnt, 1);
        check("hold.b_after_resp", acc_b - rsp_at, 1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(got, rsp_c);
        check("hold.b_rsp", {got, rsp_timeout, rsp_rdata}, {1'b1, 1'b0, 8'h5C});
        check("hold.b_seq_len", log_q.size(), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
